keypad_reader: RTL

Memory-mapped 4x4 matrix keypad input peripheral on the CPU data bus, the read-side counterpart to the seven-segment display output peripheral. It drives keypad columns one-cold in rotation and samples the rows. It debounces a single key press over whole scan frames and latches a key code for the CPU to read. Each accepted press also raises a one-cycle interrupt pulse.

---
 rtl/keypad_reader_pkg.sv | 33 +++
 rtl/keypad_reader_col_scanner.sv | 68 ++++++
 rtl/keypad_reader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/keypad_reader_pkg.sv
// Shared definitions for the keypad input peripheral: register offsets,
// controller states, the no-key sentinel and the column reset pattern.
package keypad_reader_pkg;

    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_RAW   = 2'd1;

    localparam logic [4:0] KEY_NONE  = 5'h10;
    localparam logic [3:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } key_state_t;

    // Index of the single set bit, or KEY_NONE when zero or several bits are set.
    function automatic logic [4:0] onehot_index(input logic [15:0] v);
        logic [4:0] idx;
        int         n;
        idx = KEY_NONE;
        n   = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                n++;
                idx = 5'(i);
            end
        end
        return (n == 1) ? idx : KEY_NONE;
    endfunction

endpackage

// File: rtl/keypad_reader_col_scanner.sv
// Column scanner: rotates the one-cold column drive, synchronizes the rows
// and assembles a 16-bit frame, reporting it at the end of column 3.
module keypad_col_scanner
    import keypad_reader_pkg::*;
#(
    parameter int SCAN_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    output logic [3:0]  key_col,
    output logic [15:0] bitmap,
    output logic        frame_done,
    output logic        frame_empty,
    output logic [4:0]  candidate
);

    localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    col;
    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [15:0]   frame;
    logic [15:0]   frame_next;
    logic          col_end;

    assign col_end = (cnt == CW'(SCAN_CYCLES - 1));

    // Sampling at the end of the column period hides the synchronizer delay.
    always_comb begin
        frame_next = frame;
        if (col_end) begin
            frame_next[{col, 2'b00} +: 4] = ~row_sync;
        end
    end

    assign frame_done  = col_end && (col == 2'd3);
    assign frame_empty = (frame_next == 16'h0000);
    assign candidate   = onehot_index(frame_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            col      <= 2'd0;
            key_col  <= COL_RESET;
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            frame    <= '0;
            bitmap   <= '0;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
            frame    <= frame_next;
            if (col_end) begin
                cnt     <= '0;
                col     <= col + 2'd1;
                key_col <= {key_col[2:0], key_col[3]};
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (frame_done) begin
                bitmap <= frame_next;
            end
        end
    end

endmodule

// File: rtl/keypad_reader.sv
// Memory-mapped 4x4 keypad reader: frame-level debounce FSM, latched key
// code with read-to-clear valid flag, and a one-cycle press interrupt.
//
// state      | meaning
// S_IDLE     | no key accepted, waiting for a single-key frame
// S_DEBOUNCE | counting consecutive frames of the same single key
// S_PRESSED  | press accepted, waiting for an empty frame
// S_RELEASE  | counting consecutive empty frames before re-arming
module keypad_reader
    import keypad_reader_pkg::*;
#(
    parameter int SCAN_CYCLES    = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic [3:0]  key_row,
    output logic [3:0]  key_col,
    output logic        key_irq
);

    localparam int FW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [FW-1:0] FCNT_ONE  = FW'(1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(DEBOUNCE_SCANS);

    logic [15:0]   bitmap;
    logic          frame_done;
    logic          frame_empty;
    logic [4:0]    candidate;

    key_state_t    state, state_n;
    logic [3:0]    cand, cand_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic [FW-1:0] fcnt_inc;
    logic          accept;
    logic          valid;
    logic [3:0]    code;
    logic          clr;
    logic          unused_addr;

    keypad_col_scanner #(.SCAN_CYCLES(SCAN_CYCLES)) u_scanner (
        .clk        (clk),
        .rst        (rst),
        .key_row    (key_row),
        .key_col    (key_col),
        .bitmap     (bitmap),
        .frame_done (frame_done),
        .frame_empty(frame_empty),
        .candidate  (candidate)
    );

    assign fcnt_inc    = fcnt + FCNT_ONE;
    assign clr         = re && (addr[3:2] == REG_DATA);
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    always_comb begin
        state_n = state;
        cand_n  = cand;
        fcnt_n  = fcnt;
        accept  = 1'b0;
        if (frame_done) begin
            unique case (state)
                S_IDLE: begin
                    if (candidate != KEY_NONE) begin
                        cand_n = candidate[3:0];
                        fcnt_n = FCNT_ONE;
                        if (FCNT_ONE == FCNT_LAST) begin
                            state_n = S_PRESSED;
                            accept  = 1'b1;
                        end else begin
                            state_n = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (candidate == KEY_NONE) begin
                        state_n = S_IDLE;
                    end else if (candidate[3:0] == cand) begin
                        fcnt_n = fcnt_inc;
                        if (fcnt_inc == FCNT_LAST) begin
                            state_n = S_PRESSED;
                            accept  = 1'b1;
                        end
                    end else begin
                        cand_n = candidate[3:0];
                        fcnt_n = FCNT_ONE;
                    end
                end
                // Several keys at once are not a release; only an empty frame is.
                S_PRESSED: begin
                    if (frame_empty) begin
                        fcnt_n  = FCNT_ONE;
                        state_n = (FCNT_ONE == FCNT_LAST) ? S_IDLE : S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (frame_empty) begin
                        fcnt_n = fcnt_inc;
                        if (fcnt_inc == FCNT_LAST) begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        state_n = S_PRESSED;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cand    <= '0;
            fcnt    <= '0;
            valid   <= 1'b0;
            code    <= '0;
            key_irq <= 1'b0;
        end else begin
            state   <= state_n;
            cand    <= cand_n;
            fcnt    <= fcnt_n;
            key_irq <= accept;
            valid   <= (valid && !clr) || accept;
            if (accept) begin
                code <= candidate[3:0];
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (addr[3:2])
            REG_DATA: rdata = {valid, 27'b0, code};
            REG_RAW:  rdata = {16'b0, bitmap};
            default:  rdata = 32'h0;
        endcase
    end

endmodule
